// File: rtl/registrador_acumulador_8bits_if.sv
// Operand-stage bus: mux data and buttons in, select/operand registers/status out.
interface registrador_acumulador_8bits_if #(
  parameter int unsigned LARGURA = 8
);
  logic [LARGURA-1:0] dado_mux;
  logic               botao_carrega;
  logic               botao_acumula;
  logic               sel_mux;
  logic [LARGURA-1:0] reg_a;
  logic [LARGURA-1:0] reg_b;
  logic [1:0]         estado;
  logic               pronto;
  logic [3:0]         contador_ops;

  modport master (
    output dado_mux,
    output botao_carrega,
    output botao_acumula,
    input  sel_mux,
    input  reg_a,
    input  reg_b,
    input  estado,
    input  pronto,
    input  contador_ops
  );

  modport slave (
    input  dado_mux,
    input  botao_carrega,
    input  botao_acumula,
    output sel_mux,
    output reg_a,
    output reg_b,
    output estado,
    output pronto,
    output contador_ops
  );
endinterface

// File: rtl/registrador_acumulador_8bits.sv
// Operand/accumulator register stage: button-sequenced loading of A and B,
// ALU latency wait, and optional feedback of the ALU result into A.
module registrador_acumulador_8bits #(
  parameter int unsigned LATENCIA_ULA = 2,
  parameter int unsigned LARGURA      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  registrador_acumulador_8bits_if.slave bus
);

  typedef enum logic [1:0] {
    CARREGA_A = 2'b00,
    CARREGA_B = 2'b01,
    CALCULA   = 2'b10,
    RESULTADO = 2'b11
  } estado_t;

  localparam logic [3:0] LAT_FIM = 4'(LATENCIA_ULA - 1);

  estado_t            r_estado;
  estado_t            w_prox_estado;
  logic               r_carrega_ant;
  logic               r_acumula_ant;
  logic [3:0]         r_latencia;
  logic [LARGURA-1:0] r_a;
  logic [LARGURA-1:0] r_b;
  logic [3:0]         r_ops;

  logic w_ev_carrega;
  logic w_ev_acumula;
  logic w_carrega_a;
  logic w_carrega_b;
  logic w_acumula_a;
  logic w_sel_mux;
  logic w_pronto;

  // History updates in every state, so presses seen during CALCULA are consumed.
  assign w_ev_carrega = bus.botao_carrega & ~r_carrega_ant;
  assign w_ev_acumula = bus.botao_acumula & ~r_acumula_ant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_carrega_ant <= 1'b0;
      r_acumula_ant <= 1'b0;
    end else begin
      r_carrega_ant <= bus.botao_carrega;
      r_acumula_ant <= bus.botao_acumula;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_estado <= CARREGA_A;
    end else begin
      r_estado <= w_prox_estado;
    end
  end

  always_comb begin
    w_prox_estado = r_estado;
    w_carrega_a   = 1'b0;
    w_carrega_b   = 1'b0;
    w_acumula_a   = 1'b0;
    w_sel_mux     = 1'b0;
    w_pronto      = 1'b0;
    case (r_estado)
      CARREGA_A: begin
        if (w_ev_carrega) begin
          w_carrega_a   = 1'b1;
          w_prox_estado = CARREGA_B;
        end
      end
      CARREGA_B: begin
        if (w_ev_carrega) begin
          w_carrega_b   = 1'b1;
          w_prox_estado = CALCULA;
        end
      end
      CALCULA: begin
        w_sel_mux = 1'b1;
        if (r_latencia == LAT_FIM) begin
          w_prox_estado = RESULTADO;
        end
      end
      RESULTADO: begin
        w_sel_mux = 1'b1;
        w_pronto  = 1'b1;
        if (w_ev_acumula) begin
          w_acumula_a   = 1'b1;
          w_prox_estado = CARREGA_B;
        end else if (w_ev_carrega) begin
          w_prox_estado = CARREGA_A;
        end
      end
      default: w_prox_estado = CARREGA_A;
    endcase
  end

  // Counts cycles spent in CALCULA; cleared as B is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_latencia <= '0;
    end else if (w_carrega_b) begin
      r_latencia <= '0;
    end else if (r_estado == CALCULA) begin
      r_latencia <= r_latencia + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      if (w_carrega_a || w_acumula_a) begin
        r_a <= bus.dado_mux;
      end
      if (w_carrega_b) begin
        r_b <= bus.dado_mux;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ops <= '0;
    end else if (w_carrega_a) begin
      r_ops <= '0;
    end else if (w_acumula_a && (r_ops != '1)) begin
      r_ops <= r_ops + 4'd1;
    end
  end

  assign bus.sel_mux      = w_sel_mux;
  assign bus.pronto       = w_pronto;
  assign bus.estado       = r_estado;
  assign bus.reg_a        = r_a;
  assign bus.reg_b        = r_b;
  assign bus.contador_ops = r_ops;

endmodule
